// File: rtl/pcie_cc_pkg.sv
// rtl/pcie_cc_pkg.sv - shared field map for the legacy completion header and the CC descriptor
package pcie_cc_pkg;

   localparam int         DW_PER_BEAT = 8;
   localparam logic [4:0] TYPE_CPLLK  = 5'b01011;

   // Legacy 3DW completion header, bit offsets within the first 96 bits of the beat
   localparam int LEG_LEN_LSB    = 0;
   localparam int LEG_ATTR_LSB   = 12;
   localparam int LEG_EP_BIT     = 14;
   localparam int LEG_TC_LSB     = 20;
   localparam int LEG_TYPE_LSB   = 24;
   localparam int LEG_FMT_LSB    = 29;
   localparam int LEG_BC_LSB     = 32;
   localparam int LEG_STATUS_LSB = 45;
   localparam int LEG_CID_LSB    = 48;
   localparam int LEG_LA_LSB     = 64;
   localparam int LEG_TAG_LSB    = 72;
   localparam int LEG_RID_LSB    = 80;

   // UltraScale CC descriptor, bit offsets within the first 96 bits of the beat
   localparam int CC_LA_LSB      = 0;
   localparam int CC_BC_LSB      = 16;
   localparam int CC_LOCKED_BIT  = 29;
   localparam int CC_DWC_LSB     = 32;
   localparam int CC_STATUS_LSB  = 43;
   localparam int CC_POISON_BIT  = 46;
   localparam int CC_RID_LSB     = 48;
   localparam int CC_TAG_LSB     = 64;
   localparam int CC_CID_LSB     = 72;
   localparam int CC_TC_LSB      = 89;
   localparam int CC_ATTR_LSB    = 92;

   typedef enum logic {
      ST_SOP,
      ST_BODY
   } cc_state_e;

   // Payload dwords carried by the TLP: zero for Cpl (no data), legacy length 0 encodes 1024
   function automatic logic [10:0] cc_dword_count(input logic [2:0] fmt, input logic [9:0] len);
      if (!fmt[1]) begin
         return 11'd0;
      end
      return (len == 10'd0) ? 11'd1024 : {1'b0, len};
   endfunction

endpackage

// File: rtl/s_axis_cc_skid.sv
// rtl/s_axis_cc_skid.sv - two-entry valid/ready skid buffer
module s_axis_cc_skid #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] s_tdata_i,
   input  logic             s_tvalid_i,
   output logic             s_tready_o,
   output logic [WIDTH-1:0] m_tdata_o,
   output logic             m_tvalid_o,
   input  logic             m_tready_i
);

   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] e0_q, e0_d;
   logic [WIDTH-1:0] e1_q, e1_d;
   logic             push, pop;

   // Ready depends only on occupancy, so a full buffer refuses a push even while popping
   assign s_tready_o = (cnt_q != 2'd2);
   assign m_tvalid_o = (cnt_q != 2'd0);
   assign m_tdata_o  = e0_q;
   assign push       = s_tvalid_i & s_tready_o;
   assign pop        = m_tvalid_o & m_tready_i;

   // Entry 0 is always the head; entry 1 only fills when the head is stalled
   always_comb begin
      cnt_d = cnt_q;
      e0_d  = e0_q;
      e1_d  = e1_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               e0_d = s_tdata_i;
            end else begin
               e1_d = s_tdata_i;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            // Only reachable with one entry held: the head leaves and the new beat replaces it
            e0_d = s_tdata_i;
         end
         default: begin
         end
      endcase
   end

   // Storage and occupancy registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 2'd0;
         e0_q  <= '0;
         e1_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
      end
   end

endmodule

// File: rtl/s_axis_cc_adapt_x8.sv
// rtl/s_axis_cc_adapt_x8.sv - legacy completion TLP to UltraScale CC descriptor adapter
module s_axis_cc_adapt_x8
   import pcie_cc_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  user_clk,
   input  logic                  user_reset_n,
   input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep,
   input  logic                  s_axis_cc_tlast,
   input  logic [3:0]            s_axis_cc_tuser,
   input  logic                  s_axis_cc_tvalid,
   output logic                  s_axis_cc_tready,
   output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
   output logic [7:0]            s_axis_cc_tkeep_a,
   output logic                  s_axis_cc_tlast_a,
   output logic [32:0]           s_axis_cc_tuser_a,
   output logic                  s_axis_cc_tvalid_a,
   input  logic [3:0]            s_axis_cc_tready_a,
   output logic                  len_err
);

   localparam int          DW_COUNT = DATA_WIDTH / 32;
   localparam int          SKID_W   = DATA_WIDTH + DW_COUNT + 2;
   localparam logic [10:0] DPB      = 11'(DW_PER_BEAT);

   cc_state_e             state_q, state_d;
   logic [10:0]           rem_q, rem_d;
   logic                  len_err_q, len_err_d;
   logic                  accept;
   logic [10:0]           dwc, rem_cur;
   logic                  mismatch, disc;
   logic [11:0]           bc_leg;
   logic [95:0]           desc;
   logic [DW_COUNT-1:0]   keep_dw;
   logic [DATA_WIDTH-1:0] beat_tdata;
   logic [SKID_W-1:0]     skid_in, skid_out;
   logic                  unused_bits;

   assign accept      = s_axis_cc_tvalid & s_axis_cc_tready;
   assign dwc         = cc_dword_count(s_axis_cc_tdata[LEG_FMT_LSB +: 3], s_axis_cc_tdata[LEG_LEN_LSB +: 10]);
   assign bc_leg      = s_axis_cc_tdata[LEG_BC_LSB +: 12];
   assign unused_bits = ^{s_axis_cc_tuser[2:0], s_axis_cc_tready_a[3:1], s_axis_cc_tkeep};

   // Header remap: legacy completion fields into the CC descriptor, unused descriptor bits zero
   always_comb begin
      desc                         = '0;
      desc[CC_LA_LSB +: 7]         = s_axis_cc_tdata[LEG_LA_LSB +: 7];
      desc[CC_BC_LSB +: 13]        = {(bc_leg == 12'd0), bc_leg};
      desc[CC_LOCKED_BIT]          = (s_axis_cc_tdata[LEG_TYPE_LSB +: 5] == TYPE_CPLLK);
      desc[CC_DWC_LSB +: 11]       = dwc;
      desc[CC_STATUS_LSB +: 3]     = s_axis_cc_tdata[LEG_STATUS_LSB +: 3];
      desc[CC_POISON_BIT]          = s_axis_cc_tdata[LEG_EP_BIT];
      desc[CC_RID_LSB +: 16]       = s_axis_cc_tdata[LEG_RID_LSB +: 16];
      desc[CC_TAG_LSB +: 8]        = s_axis_cc_tdata[LEG_TAG_LSB +: 8];
      desc[CC_CID_LSB +: 16]       = s_axis_cc_tdata[LEG_CID_LSB +: 16];
      desc[CC_TC_LSB +: 3]         = s_axis_cc_tdata[LEG_TC_LSB +: 3];
      desc[CC_ATTR_LSB +: 2]       = s_axis_cc_tdata[LEG_ATTR_LSB +: 2];
   end

   // Byte keep collapses to dword keep by sampling the first byte of each dword
   always_comb begin
      keep_dw = '0;
      for (int i = 0; i < DW_COUNT; i++) begin
         keep_dw[i] = s_axis_cc_tkeep[4*i];
      end
   end

   // FSM next state, remaining-dword count and length check on every accepted beat
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      len_err_d = len_err_q;
      rem_cur   = (state_q == ST_SOP) ? (11'd3 + dwc) : rem_q;
      mismatch  = s_axis_cc_tlast ? (rem_cur > DPB) : (rem_cur <= DPB);
      if (accept) begin
         rem_d   = (rem_cur > DPB) ? (rem_cur - DPB) : 11'd0;
         state_d = s_axis_cc_tlast ? ST_SOP : ST_BODY;
         if (mismatch) begin
            len_err_d = 1'b1;
         end
      end
   end

   // State, counter and sticky error registers
   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         state_q   <= ST_SOP;
         rem_q     <= 11'd0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         len_err_q <= len_err_d;
      end
   end

   assign disc       = mismatch | s_axis_cc_tuser[3];
   assign beat_tdata = (state_q == ST_SOP) ? {s_axis_cc_tdata[DATA_WIDTH-1:96], desc} : s_axis_cc_tdata;
   assign skid_in    = {beat_tdata, keep_dw, s_axis_cc_tlast, disc};

   s_axis_cc_skid #(
      .WIDTH (SKID_W)
   ) u_skid (
      .clk_i      (user_clk),
      .rst_ni     (user_reset_n),
      .s_tdata_i  (skid_in),
      .s_tvalid_i (s_axis_cc_tvalid),
      .s_tready_o (s_axis_cc_tready),
      .m_tdata_o  (skid_out),
      .m_tvalid_o (s_axis_cc_tvalid_a),
      .m_tready_i (s_axis_cc_tready_a[0])
   );

   assign s_axis_cc_tdata_a = skid_out[SKID_W-1 -: DATA_WIDTH];
   assign s_axis_cc_tkeep_a = skid_out[DW_COUNT+1:2];
   assign s_axis_cc_tlast_a = skid_out[1];
   assign s_axis_cc_tuser_a = {32'd0, skid_out[0]};
   assign len_err           = len_err_q;

endmodule

// File: tb/tb_s_axis_cc_adapt_x8.sv
// tb/tb_s_axis_cc_adapt_x8.sv - directed self-checking bench for the CC adapter
module tb_s_axis_cc_adapt_x8;

   logic         clk;
   logic         rst_n;
   logic [255:0] tdata;
   logic [31:0]  tkeep;
   logic         tlast;
   logic [3:0]   tuser;
   logic         tvalid;
   logic         tready;
   logic [255:0] tdata_a;
   logic [7:0]   tkeep_a;
   logic         tlast_a;
   logic [32:0]  tuser_a;
   logic         tvalid_a;
   logic [3:0]   tready_a;
   logic         len_err;

   typedef struct packed {
      logic [255:0] d;
      logic [7:0]   k;
      logic         l;
      logic         e;
   } beat_t;

   beat_t capq[$];
   int    ntests = 0;
   int    nfail  = 0;
   int    occ    = 0;
   int    rdy_bad = 0;
   int    rdy_low = 0;
   logic  done5;

   s_axis_cc_adapt_x8 dut (
      .user_clk           (clk),
      .user_reset_n       (rst_n),
      .s_axis_cc_tdata    (tdata),
      .s_axis_cc_tkeep    (tkeep),
      .s_axis_cc_tlast    (tlast),
      .s_axis_cc_tuser    (tuser),
      .s_axis_cc_tvalid   (tvalid),
      .s_axis_cc_tready   (tready),
      .s_axis_cc_tdata_a  (tdata_a),
      .s_axis_cc_tkeep_a  (tkeep_a),
      .s_axis_cc_tlast_a  (tlast_a),
      .s_axis_cc_tuser_a  (tuser_a),
      .s_axis_cc_tvalid_a (tvalid_a),
      .s_axis_cc_tready_a (tready_a),
      .len_err            (len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture output transfers and track expected occupancy, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         occ = 0;
      end else begin
         if (tready !== (occ < 2)) rdy_bad++;
         if (!tready) rdy_low++;
         if (tvalid_a && tready_a[0]) begin
            capq.push_back('{d: tdata_a, k: tkeep_a, l: tlast_a, e: tuser_a[0]});
            occ--;
         end
         if (tvalid && tready) occ++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] leg(input logic [31:0] dw0, input logic [31:0] dw1,
                                        input logic [31:0] dw2, input logic [159:0] pl);
      return {pl, dw2, dw1, dw0};
   endfunction

   task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l, input logic [3:0] u);
      logic ok;
      int   n;
      tdata  = d;
      tkeep  = k;
      tlast  = l;
      tuser  = u;
      tvalid = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = tready;
         @(posedge clk);
         #1;
         n++;
      end
      chk("send_timeout", 256'(ok), 256'd1);
   endtask

   task automatic idle();
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 4'd0;
   endtask

   task automatic get_beat(output beat_t b);
      int n;
      n = 0;
      while (capq.size() == 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("capture_timeout", 256'(capq.size() > 0), 256'd1);
      if (capq.size() > 0) b = capq.pop_front();
      else b = '0;
   endtask

   initial begin
      beat_t        b;
      logic [159:0] pl;
      logic [255:0] d1, d2;
      logic [255:0] e5_d [12];
      logic [9:0]   e5_kl [12];

      rst_n    = 1'b0;
      tdata    = '0;
      tkeep    = '0;
      tlast    = 1'b0;
      tuser    = 4'd0;
      tvalid   = 1'b0;
      tready_a = 4'hF;
      done5    = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_tvalid_a", 256'(tvalid_a), 256'd0);
      chk("rst_tdata_a", tdata_a, 256'd0);
      chk("rst_side", 256'({tkeep_a, tlast_a, tuser_a}), 256'd0);
      chk("rst_tready", 256'(tready), 256'd1);
      chk("rst_len_err", 256'(len_err), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: CplD len=1 bc=4 la=0x10 tag=0x2A, single beat
      pl = {5{32'h1111_0001}};
      send(leg(32'h4A00_0001, 32'h0100_0004, 32'h0200_2A10, pl), 32'h0000_FFFF, 1'b1, 4'd0);
      chk("t1_latency_valid", 256'(tvalid_a), 256'd1);
      chk("t1_latency_dw0", 256'(tdata_a[31:0]), 256'h0004_0010);
      idle();
      get_beat(b);
      chk("t1_data", b.d, {pl, 32'h0001_002A, 32'h0200_0001, 32'h0004_0010});
      chk("t1_keep_last_disc", 256'({b.k, b.l, b.e}), 256'({8'h0F, 1'b1, 1'b0}));

      // 2: CplD len=16 TC=3 attr=2 tag=5, three beats
      pl = {5{32'h2222_0000}};
      d1 = {8{32'hB0B0_0001}};
      d2 = {8{32'hB0B0_0002}};
      send(leg(32'h4A30_2010, 32'h0000_0040, 32'h0000_0500, pl), 32'hFFFF_FFFF, 1'b0, 4'd0);
      send(d1, 32'hFFFF_FFFF, 1'b0, 4'd0);
      send(d2, 32'h0000_0FFF, 1'b1, 4'd0);
      idle();
      get_beat(b);
      chk("t2_sop_data", b.d, {pl, 32'h2600_0005, 32'h0000_0010, 32'h0040_0000});
      chk("t2_b0_side", 256'({b.k, b.l, b.e}), 256'({8'hFF, 1'b0, 1'b0}));
      get_beat(b);
      chk("t2_b1_data", b.d, d1);
      chk("t2_b1_side", 256'({b.k, b.l, b.e}), 256'({8'hFF, 1'b0, 1'b0}));
      get_beat(b);
      chk("t2_b2_data", b.d, d2);
      chk("t2_b2_side", 256'({b.k, b.l, b.e}), 256'({8'h07, 1'b1, 1'b0}));
      chk("t2_len_err", 256'(len_err), 256'd0);

      // 2b: source discontinue on a well-formed single-beat TLP
      pl = {5{32'h1111_0002}};
      send(leg(32'h4A00_0001, 32'h0100_0004, 32'h0200_2A10, pl), 32'h0000_FFFF, 1'b1, 4'b1000);
      idle();
      get_beat(b);
      chk("t2b_data", b.d, {pl, 32'h0001_002A, 32'h0200_0001, 32'h0004_0010});
      chk("t2b_disc", 256'(b.e), 256'd1);
      chk("t2b_len_err", 256'(len_err), 256'd0);

      // 3: Cpl without data, status UR, byte count 0 means 4096
      pl = {5{32'h3333_0000}};
      send(leg(32'h0A00_0000, 32'h0000_2000, 32'h0000_0000, pl), 32'h0000_0FFF, 1'b1, 4'd0);
      idle();
      get_beat(b);
      chk("t3_data", b.d, {pl, 32'h0000_0000, 32'h0000_0800, 32'h1000_0000});
      chk("t3_side", 256'({b.k, b.l, b.e}), 256'({8'h07, 1'b1, 1'b0}));

      // 4: CplD len=16 but tlast on beat 2
      pl = {5{32'h4444_0000}};
      d1 = {8{32'hC4C4_0001}};
      send(leg(32'h4A00_0010, 32'h0000_0040, 32'h0000_0000, pl), 32'hFFFF_FFFF, 1'b0, 4'd0);
      send(d1, 32'h0000_0FFF, 1'b1, 4'd0);
      idle();
      get_beat(b);
      chk("t4_sop_data", b.d, {pl, 32'h0000_0000, 32'h0000_0010, 32'h0040_0000});
      chk("t4_b0_disc", 256'(b.e), 256'd0);
      get_beat(b);
      chk("t4_b1_data", b.d, d1);
      chk("t4_b1_side", 256'({b.k, b.l, b.e}), 256'({8'h07, 1'b1, 1'b1}));
      chk("t4_len_err", 256'(len_err), 256'd1);

      // 3b: CplDLk len=0 (1024 dwords) ended after one beat
      pl = {5{32'h5555_0000}};
      send(leg(32'h4B00_0000, 32'h0000_0000, 32'h0000_0000, pl), 32'hFFFF_FFFF, 1'b1, 4'd0);
      idle();
      get_beat(b);
      chk("t3b_data", b.d, {pl, 32'h0000_0000, 32'h0000_0400, 32'h3000_0000});
      chk("t3b_side", 256'({b.k, b.l, b.e}), 256'({8'hFF, 1'b1, 1'b1}));
      chk("t3b_len_err_held", 256'(len_err), 256'd1);

      // 5: four back-to-back 3-beat TLPs with output ready toggling every cycle
      for (int t = 0; t < 4; t++) begin
         e5_d[3*t]    = {{5{32'hC0DE_0000 | 32'(t)}}, 96'd0};
         e5_d[3*t+1]  = {8{32'hA500_0000 | 32'(t << 8) | 32'd1}};
         e5_d[3*t+2]  = {8{32'hA500_0000 | 32'(t << 8) | 32'd2}};
         e5_kl[3*t]   = {8'hFF, 1'b0, 1'b0};
         e5_kl[3*t+1] = {8'hFF, 1'b0, 1'b0};
         e5_kl[3*t+2] = {8'h07, 1'b1, 1'b0};
      end
      rdy_low = 0;
      fork
         begin
            for (int t = 0; t < 4; t++) begin
               send(leg(32'h4A00_0010, 32'h0000_0040, {16'd0, 8'(t), 8'd0}, e5_d[3*t][255:96]),
                    32'hFFFF_FFFF, 1'b0, 4'd0);
               send(e5_d[3*t+1], 32'hFFFF_FFFF, 1'b0, 4'd0);
               send(e5_d[3*t+2], 32'h0000_0FFF, 1'b1, 4'd0);
            end
            idle();
            done5 = 1'b1;
         end
         begin
            int n;
            n = 0;
            tready_a = 4'hF;
            while (!done5 && n < 500) begin
               @(posedge clk);
               #1;
               tready_a[0] = ~tready_a[0];
               n++;
            end
         end
      join
      tready_a = 4'hF;
      for (int i = 0; i < 12; i++) begin
         get_beat(b);
         if (i % 3 == 0) begin
            chk($sformatf("t5_payload_%0d", i), 256'(b.d[255:96]), 256'(e5_d[i][255:96]));
            chk($sformatf("t5_dwc_%0d", i), 256'(b.d[42:32]), 256'd16);
         end else begin
            chk($sformatf("t5_data_%0d", i), b.d, e5_d[i]);
         end
         chk($sformatf("t5_side_%0d", i), 256'({b.k, b.l, b.e}), 256'(e5_kl[i]));
      end
      repeat (4) @(posedge clk);
      #1;
      chk("t5_no_extra", 256'(capq.size()), 256'd0);
      chk("t5_ready_rule", 256'(rdy_bad), 256'd0);
      chk("t5_backpressure_seen", 256'(rdy_low > 0), 256'd1);

      // 6: reset pulsed during beat 2 of a TLP
      pl = {5{32'h6666_0000}};
      send(leg(32'h4A00_0010, 32'h0000_0040, 32'h0000_0000, pl), 32'hFFFF_FFFF, 1'b0, 4'd0);
      tdata = {8{32'hDEAD_0002}};
      tkeep = 32'hFFFF_FFFF;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_tvalid_a_reset", 256'(tvalid_a), 256'd0);
      chk("t6_tready_reset", 256'(tready), 256'd1);
      chk("t6_len_err_reset", 256'(len_err), 256'd0);
      idle();
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      capq.delete();
      @(posedge clk);
      #1;
      pl = {5{32'h1111_0006}};
      send(leg(32'h4A00_0001, 32'h0100_0004, 32'h0200_2A10, pl), 32'h0000_FFFF, 1'b1, 4'd0);
      idle();
      get_beat(b);
      chk("t6_sop_data", b.d, {pl, 32'h0001_002A, 32'h0200_0001, 32'h0004_0010});
      chk("t6_sop_side", 256'({b.k, b.l, b.e}), 256'({8'h0F, 1'b1, 1'b0}));
      chk("t6_len_err", 256'(len_err), 256'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
